// File: rtl/loader_pkg.sv
// Shared types, ASCII constants and hex decode helpers for the UART hex DAC loader.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_P  = 8'h50;
    localparam logic [7:0] ASCII_X  = 8'h58;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_QM = 8'h3F;

    // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] b);
        logic [4:0] res;
        res = 5'b0;
        if (b >= 8'h30 && b <= 8'h39) begin
            res = {1'b1, b[3:0]};
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            res = {1'b1, b[3:0] + 4'd9};
        end
        return res;
    endfunction

    // Case-insensitive match of a byte against an uppercase letter.
    function automatic logic is_letter(input logic [7:0] b, input logic [7:0] upper);
        return (b | 8'h20) == (upper | 8'h20);
    endfunction

endpackage

// File: rtl/hex_line_parser.sv
// Assembles one ASCII-hex line into a DAC word; pulses line_ok_o/line_bad_o on LF.
module hex_line_parser
    import loader_pkg::*;
#(
    parameter int unsigned DAC_BITLEN = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  line_ok_o,
    output logic                  line_bad_o,
    output logic [DAC_BITLEN-1:0] word_o
);

    localparam int unsigned NIBBLES = DAC_BITLEN / 4;
    localparam int unsigned CW      = $clog2(NIBBLES + 1);

    logic [DAC_BITLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]         ncnt_q, ncnt_d;
    logic                  bad_q, bad_d;
    logic [4:0]            hex;

    always_comb begin
        hex        = hex_to_nibble(byte_i);
        acc_d      = acc_q;
        ncnt_d     = ncnt_q;
        bad_d      = bad_q;
        line_ok_o  = 1'b0;
        line_bad_o = 1'b0;
        if (clear_i) begin
            acc_d  = '0;
            ncnt_d = '0;
            bad_d  = 1'b0;
        end else if (byte_valid_i) begin
            if (byte_i == ASCII_LF) begin
                if (ncnt_q == CW'(NIBBLES) && !bad_q) begin
                    line_ok_o = 1'b1;
                end else begin
                    line_bad_o = 1'b1;
                end
                acc_d  = '0;
                ncnt_d = '0;
                bad_d  = 1'b0;
            end else if (byte_i == ASCII_CR) begin
                bad_d = bad_q;
            end else if (hex[4]) begin
                // A digit beyond the word width poisons the line rather than shifting.
                if (ncnt_q == CW'(NIBBLES)) begin
                    bad_d = 1'b1;
                end else begin
                    acc_d  = DAC_BITLEN'({acc_q, hex[3:0]});
                    ncnt_d = ncnt_q + 1'b1;
                end
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ncnt_q <= '0;
            bad_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ncnt_q <= ncnt_d;
            bad_q  <= bad_d;
        end
    end

    assign word_o = acc_q;

endmodule

// File: rtl/uart_hex_dac_loader.sv
// Loads ASCII-hex samples from UART into memory and replays them to the DAC in a loop.
// Define UART_HEX_LOADER_ACK_EN to enable the 'K'/'?' ack bytes on tvalid/tdata.
module uart_hex_dac_loader
    import loader_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 4096,
    parameter int unsigned DAC_BITLEN  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [7:0]            rdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic [7:0]            tdata,
    input  logic                  dac_ready,
    output logic [DAC_BITLEN-1:0] dac_input,
    output logic                  loaded,
    output logic                  playing,
    output logic [15:0]           bad_lines
);

    localparam int unsigned          AW       = $clog2(NUM_SAMPLES);
    localparam logic [DAC_BITLEN-1:0] MIDSCALE = {1'b1, {(DAC_BITLEN-1){1'b0}}};

    state_e                state_q, state_d;
    logic                  rready_q;
    logic                  loaded_q, loaded_d;
    logic [AW-1:0]         wr_idx_q, wr_idx_d;
    logic [AW-1:0]         rd_idx_q, rd_idx_d;
    logic [DAC_BITLEN-1:0] dac_q, dac_d;
    logic [15:0]           bad_q, bad_d;
    logic [DAC_BITLEN-1:0] prefetch_q;
    logic [DAC_BITLEN-1:0] mem [NUM_SAMPLES];

    logic                  consume;
    logic                  is_l, is_p, is_x;
    logic                  parser_clear, parser_valid;
    logic                  line_ok, line_bad;
    logic [DAC_BITLEN-1:0] line_word;
    logic                  load_done;

    assign consume      = rvalid & rready_q;
    assign is_l         = is_letter(rdata, ASCII_L);
    assign is_p         = is_letter(rdata, ASCII_P);
    assign is_x         = is_letter(rdata, ASCII_X);
    assign parser_clear = consume && (state_q == ST_IDLE) && is_l;
    assign parser_valid = consume && (state_q == ST_LOAD) && !is_x;
    assign load_done    = line_ok && (wr_idx_q == AW'(NUM_SAMPLES - 1));

    hex_line_parser #(
        .DAC_BITLEN (DAC_BITLEN)
    ) u_parser (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (parser_clear),
        .byte_valid_i (parser_valid),
        .byte_i       (rdata),
        .line_ok_o    (line_ok),
        .line_bad_o   (line_bad),
        .word_o       (line_word)
    );

    // Accept at most one byte every two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rready_q <= 1'b0;
        end else begin
            rready_q <= rvalid & ~rready_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        dac_d    = dac_q;
        bad_d    = bad_q;

        if (line_bad && bad_q != 16'hFFFF) begin
            bad_d = bad_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                rd_idx_d = '0;
                dac_d    = MIDSCALE;
                if (consume) begin
                    if (is_l) begin
                        state_d  = ST_LOAD;
                        loaded_d = 1'b0;
                        wr_idx_d = '0;
                    end else if (is_p && loaded_q) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_LOAD: begin
                rd_idx_d = '0;
                dac_d    = MIDSCALE;
                if (consume && is_x) begin
                    state_d = ST_IDLE;
                end else if (line_ok) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (load_done) begin
                        state_d  = ST_IDLE;
                        loaded_d = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // A sample request coincident with 'X' still wins; MIDSCALE follows from IDLE.
                if (dac_ready) begin
                    dac_d    = prefetch_q;
                    rd_idx_d = rd_idx_q + 1'b1;
                end
                if (consume && is_x) begin
                    state_d = ST_IDLE;
                    if (!dac_ready) begin
                        dac_d = MIDSCALE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                dac_d   = MIDSCALE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            loaded_q <= 1'b0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            dac_q    <= MIDSCALE;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            dac_q    <= dac_d;
            bad_q    <= bad_d;
        end
    end

    // Sample memory: no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (line_ok) begin
            mem[wr_idx_q] <= line_word;
        end
        prefetch_q <= mem[rd_idx_q];
    end

`ifdef UART_HEX_LOADER_ACK_EN
    logic       tvalid_q, tvalid_d;
    logic [7:0] tdata_q, tdata_d;
    logic       p_reject;

    assign p_reject = consume && (state_q == ST_IDLE) && !is_l && is_p && !loaded_q;

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (tvalid_q) begin
            if (tready) begin
                tvalid_d = 1'b0;
            end
        end else if (load_done) begin
            tvalid_d = 1'b1;
            tdata_d  = ASCII_K;
        end else if (line_bad || p_reject) begin
            tvalid_d = 1'b1;
            tdata_d  = ASCII_QM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;
`else
    logic unused_ack;
    assign unused_ack = tready;
    assign tvalid     = 1'b0;
    assign tdata      = '0;
`endif

    assign rready    = rready_q;
    assign dac_input = dac_q;
    assign loaded    = loaded_q;
    assign playing   = (state_q == ST_PLAY);
    assign bad_lines = bad_q;

endmodule
